// File: rtl/serial_to_parallel.sv
// MSB-first serial-to-parallel deserializer with a small circular output buffer.
// Truncated bursts raise frame_err; words arriving at a full buffer raise overflow.
module serial_to_parallel #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din_valid,
    input  logic                         din_serial,
    output logic [WIDTH-1:0]             dout_parallel,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         frame_err,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     count, count_next;
    logic [WIDTH-1:0]     shreg, shreg_next;
    logic [WIDTH-1:0]     word;
    logic                 word_done;
    logic                 frame_next;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, wr_next, rd_next;
    logic [LVL_W-1:0]     level_next;
    logic [WIDTH-1:0]     head_next;
    logic                 pop, push, drop, full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign word = {shreg[WIDTH-2:0], din_serial};

    always_comb begin
        state_next = state;
        count_next = count;
        shreg_next = shreg;
        word_done  = 1'b0;
        frame_next = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    shreg_next = word;
                    count_next = CNT_W'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (din_valid) begin
                    shreg_next = word;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        word_done  = 1'b1;
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end else begin
                    count_next = '0;
                    frame_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A simultaneous pop frees the slot, so a completing word is never dropped then.
    always_comb begin
        pop        = dout_valid && dout_ready;
        full       = (level == LVL_W'(DEPTH));
        push       = word_done && (!full || pop);
        drop       = word_done && !push;
        rd_next    = pop  ? ptr_inc(rd_ptr) : rd_ptr;
        wr_next    = push ? ptr_inc(wr_ptr) : wr_ptr;
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push) begin
            level_next = level - 1'b1;
        end
        head_next = (push && (wr_ptr == rd_next)) ? word : mem[rd_next];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            shreg         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            dout_valid    <= 1'b0;
            dout_parallel <= '0;
            frame_err     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            shreg      <= shreg_next;
            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            level      <= level_next;
            dout_valid <= (level_next != '0);
            if (level_next != '0) begin
                dout_parallel <= head_next;
            end
            frame_err  <= frame_next;
            overflow   <= drop;
        end
    end

    // Storage needs no reset: occupancy and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_serial_to_parallel;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             din_valid;
    logic             din_serial;
    logic [WIDTH-1:0] dout_parallel;
    logic             dout_valid;
    logic             dout_ready;
    logic             frame_err;
    logic             overflow;
    logic [LVL_W-1:0] level;

    int tests  = 0;
    int failed = 0;

    // Reference model: word queue, partial-word bit count and accumulated value.
    logic [WIDTH-1:0] mq[$];
    int               bit_cnt;
    int               acc_val;
    logic             exp_fe;
    logic             exp_ovf;

    serial_to_parallel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .din_valid(din_valid),
        .din_serial(din_serial),
        .dout_parallel(dout_parallel),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .frame_err(frame_err),
        .overflow(overflow),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        mq.delete();
        bit_cnt = 0;
        acc_val = 0;
        exp_fe  = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic modelStep(input logic v, input logic d, input logic r);
        bit               do_pop;
        bit               done;
        logic [WIDTH-1:0] w;
        do_pop  = (mq.size() > 0) && r;
        done    = 1'b0;
        w       = '0;
        exp_fe  = (bit_cnt > 0) && !v;
        exp_ovf = 1'b0;
        if (v) begin
            acc_val = (acc_val * 2 + int'(d)) % (1 << WIDTH);
            bit_cnt++;
            if (bit_cnt == WIDTH) begin
                done    = 1'b1;
                w       = WIDTH'(acc_val);
                bit_cnt = 0;
                acc_val = 0;
            end
        end else begin
            bit_cnt = 0;
            acc_val = 0;
        end
        if (do_pop) void'(mq.pop_front());
        if (done) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        compareValue({tag, "_valid"}, 32'(dout_valid), 32'(mq.size() != 0));
        compareValue({tag, "_level"}, 32'(level), 32'(mq.size()));
        if (mq.size() > 0) compareValue({tag, "_data"}, 32'(dout_parallel), 32'(mq[0]));
        compareValue({tag, "_frame_err"}, 32'(frame_err), 32'(exp_fe));
        compareValue({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic applyStimulus(input logic v, input logic d, input logic r, input string tag);
        din_valid  = v;
        din_serial = d;
        dout_ready = r;
        modelStep(v, d, r);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] w, input logic r, input logic r_last, input string tag);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            applyStimulus(1'b1, w[i], (i == 0) ? r_last : r, tag);
        end
    endtask

    task automatic idle(input int n, input logic r, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, r, tag);
    endtask

    task automatic resetDut();
        rst        = 1'b1;
        din_valid  = 1'b0;
        din_serial = 1'b0;
        dout_ready = 1'b0;
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        compareValue("reset_dout", 32'(dout_parallel), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        din_valid  = 1'b0;
        din_serial = 1'b0;
        dout_ready = 1'b0;
        modelClear();
        #2;
        resetDut();

        // Single word, consumer always ready.
        sendWord(8'hB2, 1'b1, 1'b1, "b2");
        compareValue("b2_head", 32'(dout_parallel), 32'hB2);
        idle(3, 1'b1, "b2_drain");
        compareValue("b2_empty", 32'(level), 32'h0);

        // Two separate bursts.
        sendWord(8'hA5, 1'b1, 1'b1, "a5");
        compareValue("a5_head", 32'(dout_parallel), 32'hA5);
        idle(2, 1'b1, "gap");
        sendWord(8'h3C, 1'b1, 1'b1, "3c");
        compareValue("3c_head", 32'(dout_parallel), 32'h3C);
        idle(2, 1'b1, "3c_drain");

        // Back-to-back words fill the buffer with the consumer stalled.
        sendWord(8'hFF, 1'b0, 1'b0, "ff");
        sendWord(8'h01, 1'b0, 1'b0, "01");
        idle(2, 1'b0, "full_hold");
        compareValue("full_level", 32'(level), 32'(DEPTH));
        compareValue("full_head", 32'(dout_parallel), 32'hFF);

        // Third word into a full buffer is dropped.
        sendWord(8'h55, 1'b0, 1'b0, "ovf");
        compareValue("ovf_pulse", 32'(overflow), 32'h1);
        compareValue("ovf_head", 32'(dout_parallel), 32'hFF);
        idle(1, 1'b0, "ovf_after");
        compareValue("ovf_one_cycle", 32'(overflow), 32'h0);

        // Same again with a pop on the completion cycle: accepted.
        sendWord(8'h55, 1'b0, 1'b1, "push_pop");
        compareValue("push_pop_ovf", 32'(overflow), 32'h0);
        compareValue("push_pop_head", 32'(dout_parallel), 32'h01);
        compareValue("push_pop_level", 32'(level), 32'(DEPTH));
        applyStimulus(1'b0, 1'b0, 1'b1, "pop01");
        compareValue("tail_55", 32'(dout_parallel), 32'h55);
        idle(2, 1'b1, "drain55");

        // Truncated burst after five bits.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'(i & 1), 1'b1, "partial");
        applyStimulus(1'b0, 1'b1, 1'b1, "gap_err");
        compareValue("frame_pulse", 32'(frame_err), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, "gap_after");
        compareValue("frame_one_cycle", 32'(frame_err), 32'h0);
        sendWord(8'h81, 1'b1, 1'b1, "81");
        compareValue("81_head", 32'(dout_parallel), 32'h81);
        idle(2, 1'b1, "81_drain");

        // Async reset mid-word with one word buffered.
        sendWord(8'h5A, 1'b0, 1'b0, "pre_rst");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, "mid_word");
        #2;
        rst = 1'b1;
        #1;
        compareValue("async_valid", 32'(dout_valid), 32'h0);
        compareValue("async_level", 32'(level), 32'h0);
        compareValue("async_frame", 32'(frame_err), 32'h0);
        compareValue("async_ovf", 32'(overflow), 32'h0);
        modelClear();
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sendWord(8'h7E, 1'b1, 1'b1, "7e");
        compareValue("7e_head", 32'(dout_parallel), 32'h7E);
        idle(2, 1'b1, "7e_drain");

        // Random traffic with gaps and consumer stalls.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 9, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 2) != 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Deserializer sitting directly downstream of the team's 8-bit parallel-to-serial stage.
- Consumes its MSB-first serial stream (valid-qualified, one bit per clock) and reassembles WIDTH-bit words.
- Queues the words in a small output buffer for a valid/ready consumer.
- Flags framing errors (truncated bursts) and buffer overflow.

Parameters:
- WIDTH, 8: bits per word; must be >= 2.
- DEPTH, 2: output buffer entries, a power of two, >= 1.

Ports:
- clk  input  1  single clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din_valid  input  1  serial bit qualifier; high means din_serial carries a valid bit this cycle.
- din_serial  input  1  serial data, MSB of each word first.
- dout_parallel  output  WIDTH  head-of-buffer word.
- dout_valid  output  1  buffer non-empty; dout_parallel is valid.
- dout_ready  input  1  consumer accepts the head word when dout_valid && dout_ready.
- frame_err  output  1  one-cycle pulse: a partial word was discarded.
- overflow  output  1  one-cycle pulse: a complete word was dropped because the buffer was full.
- level  output  $clog2(DEPTH+1)  current buffer occupancy.

Behaviour:
- Reset (async assert, sync deassert by upstream reset logic):
  - State goes to IDLE; bit counter = 0; shift register = 0.
  - Buffer is emptied: dout_valid = 0, dout_parallel = 0, level = 0.
  - frame_err = 0, overflow = 0.
  - Reset mid-word or with a full buffer discards everything; there is no partial recovery.
- Shift path, FSM states IDLE and SHIFT:
  - IDLE: on din_valid=1, sample din_serial into shreg LSB, count=1, go to SHIFT.
  - SHIFT: each cycle with din_valid=1, shreg <= {shreg[WIDTH-2:0], din_serial} and count++.
  - When the WIDTH-th bit is sampled, word = {shreg[WIDTH-2:0], din_serial}. The word is pushed, count resets to 0, and the state goes to IDLE.
  - SHIFT with din_valid=0 (gap mid-word):
    - Discard the partial word and set count=0.
    - frame_err=1 for exactly the next cycle; go to IDLE.
  - Back-to-back words are accepted with no idle cycle: din_valid held high for k*WIDTH cycles yields k words. The first bit of word n+1 may arrive in the cycle after the last bit of word n.
  - din_serial is ignored whenever din_valid=0.
- Output buffer, circular, DEPTH entries:
  - Push on word completion; pop on dout_valid && dout_ready.
  - Pushed word is visible on dout_parallel/dout_valid in the cycle after its last bit is sampled, if the buffer was empty (1-cycle latency).
  - dout_parallel and dout_valid are registered. The head is stable while dout_valid && !dout_ready.
  - Push and pop in the same cycle: both occur and level is unchanged, including when full. The completed word is accepted; no overflow.
  - Push when full with no pop: the new word is dropped, buffer contents are unchanged, and overflow=1 for the next cycle.
  - Pop when empty: no effect.
  - Pointers wrap modulo DEPTH.
  - When empty, dout_parallel holds its last value; it is don't-care for checkers.
- frame_err and overflow are independent and may pulse in the same cycle.

Test Plan:
- Reset, then din_valid high for 8 cycles with bits 1,0,1,1,0,0,1,0 and dout_ready=1 -> one cycle after the 8th bit: dout_valid=1, dout_parallel=8'hB2; popped next cycle; level returns to 0.
- Upstream stage connected, feeding 8'hA5 then 8'h3C, each as a separate burst -> two words in order, 8'hA5 then 8'h3C; frame_err never asserts.
- din_valid high for 16 consecutive cycles carrying 8'hFF then 8'h01, with dout_ready=0 and DEPTH=2 -> level=2; head=8'hFF held stable; overflow never asserts.
- Buffer full with dout_ready=0 and a third word 8'h55 completes -> overflow pulses for 1 cycle; head stays 8'hFF; level stays 2. Repeat with dout_ready=1 on the completion cycle -> no overflow; 8'h55 becomes the tail.
- din_valid high for 5 bits, then low -> frame_err high for exactly 1 cycle; no push. The next clean 8-bit burst carrying 8'h81 outputs 8'h81.
- Async rst asserted mid-word with level=1 -> dout_valid, level, frame_err and overflow go to 0 immediately. After release, a fresh 8'h7E burst outputs 8'h7E.
